wireless_poller: RTL and testbench
==================================

Name: wireless_poller

Overview:
- Initiator end of the Bluetooth byte protocol; it plays the Android-app role for bench and board-to-board links.
- Drives a UART toward a remote sensor-side responder. Periodically requests heart rate, angle sign, angle value and speed. Reassembles the one-byte replies into coherent registers.
- Issues heart-cap and wheel-size configuration writes on request.
- Sits between the UART module and display/logging logic.

Parameters:
- POLL_CYCLES, 5_000_000: clk cycles from the start of one poll round to the start of the next (100 ms at 50 MHz).
- RESP_TIMEOUT, 500_000: clk cycles allowed from the transmit pulse to the reply `received` pulse.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  master clock
- rst_n  in  1  asynchronous active-low reset
- transmit  out  1  one-cycle pulse that loads tx_byte into the UART
- tx_byte  out  8  request byte
- received  in  1  one-cycle pulse: rx_byte is valid
- rx_byte  in  8  reply byte
- is_transmitting  in  1  UART transmit line busy
- recv_error  in  1  UART framing error pulse
- cfg_heart_req  in  1  pulse: write cfg_heart_val as the remote heart cap
- cfg_heart_val  in  8  heart-cap value
- cfg_wheel_req  in  1  pulse: write cfg_wheel_val as the remote wheel size
- cfg_wheel_val  in  8  wheel-size value
- cfg_done  out  1  pulse: configuration sequence finished
- cfg_err  out  1  valid with cfg_done; 1 means the sequence failed
- heartRate  out  8  last committed heart rate
- resolvedAngle  out  10  last committed angle; {sign reply[1:0], value reply}
- speed  out  8  last committed speed
- data_valid  out  1  pulse: a new round was committed
- link_ok  out  1  last transaction succeeded
- err_count  out  ERR_W  saturating count of failed transactions

Behaviour:
- Reset (async, rst_n low): every output is 0, FSM is in IDLE, poll timer is 0, pending-config flags are cleared.
- Command codes: HR=1, ANGLE_SIGN=2, ANGLE_VALUE=3, SPEED=4, INIT_HEART=5, INIT_WHEEL=6. The configuration acknowledge byte is 1.
- Transaction (sub-module):
  - Waits for is_transmitting=0, then asserts transmit for exactly 1 cycle with tx_byte held stable.
  - Starts the timeout counter in the cycle after the transmit pulse.
  - Success: a `received` pulse arrives before the counter reaches RESP_TIMEOUT; rx_byte is captured.
  - Failure: timeout, or recv_error while waiting.
  - Only one request is outstanding at a time. `received` pulses outside the wait state are ignored.
- Top FSM states: IDLE, POLL_HR, POLL_SIGN, POLL_VAL, POLL_SPD, COMMIT, CFG_INIT, CFG_VAL, CFG_END.
- Poll timer:
  - Free-running, counting 0..POLL_CYCLES-1.
  - At wrap, IDLE starts a round; a wrap that occurs while a round or configuration sequence is busy is dropped, not queued.
- Configuration priority:
  - A pending configuration is serviced from IDLE before a poll round.
  - Heart is serviced before wheel when both are pending.
  - Requests are latched at the pulse, together with the value. A repeat request while the same kind is pending overwrites the value.
- Poll round:
  - HR→SIGN→VAL→SPD, with replies held in shadow registers.
  - COMMIT copies all four shadow values to the outputs in one cycle, pulses data_valid and sets link_ok=1.
  - Any failure aborts the round: outputs keep their previous values, link_ok=0, err_count increments (saturating), and the FSM returns to IDLE.
- Configuration sequence:
  - CFG_INIT sends 5 (heart) or 6 (wheel). A reply other than 1 is a failure.
  - CFG_VAL sends the latched value as a raw byte. A reply other than 1 is a failure.
  - CFG_END pulses cfg_done, with cfg_err=1 on any failure, then clears the pending flag.
  - No retries; failure increments err_count and sets link_ok=0. Resynchronising a responder left in its init state is a higher-level concern.
- Mid-operation reset: the transaction is abandoned immediately, and no transmit pulse is emitted while rst_n is low.
- Width rules: resolvedAngle[9:8] = sign reply[1:0], and sign reply[7:2] is discarded. Timer widths are $clog2(param)+1.

Decomposition:
- Package wireless_pkg: the command-code localparams, the ACK constant, and the poller state enum.
- Sub-module wireless_txn:
  - Inputs: start, req_byte.
  - Outputs: done, ok, resp_byte; it owns the transmit handshake and the timeout counter.
- The top module holds the FSM, shadow registers, config latches and counters.

Test Plan:
- Responder model replies HR=72, sign=2'b10, value=8'h3C, speed=25 → after one round, heartRate=72, resolvedAngle=10'h23C, speed=25, one data_valid pulse, link_ok=1.
- Responder silent on ANGLE_VALUE (POLL_CYCLES=2000, RESP_TIMEOUT=100) → no data_valid, outputs unchanged, err_count=1, link_ok=0, next round proceeds normally.
- cfg_heart_req with value 180, responder acks 1,1 → tx sequence 5 then 180 (each transmit only when is_transmitting=0), cfg_done=1 with cfg_err=0.
- cfg_heart_req and cfg_wheel_req in the same cycle (values 190, 26) → tx order 5,190,6,26 before the next poll round; two cfg_done pulses.
- INIT_WHEEL answered with 0 → cfg_done with cfg_err=1, value byte never sent, err_count increments.
- rst_n pulled low while waiting for the SPD reply → all outputs 0 asynchronously; after release, the first transmit occurs at the first timer wrap with tx_byte=1.

Source files
------------

// File: rtl/wireless_pkg.sv
// Shared constants and state encodings for the wireless poller.
// No logic; command codes, the config acknowledge byte and FSM encodings.
// Imported by the poller top and its transaction engine.
package wireless_pkg;

    localparam logic [7:0] CMD_HR          = 8'd1;
    localparam logic [7:0] CMD_ANGLE_SIGN  = 8'd2;
    localparam logic [7:0] CMD_ANGLE_VALUE = 8'd3;
    localparam logic [7:0] CMD_SPEED       = 8'd4;
    localparam logic [7:0] CMD_INIT_HEART  = 8'd5;
    localparam logic [7:0] CMD_INIT_WHEEL  = 8'd6;
    localparam logic [7:0] CFG_ACK         = 8'd1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_POLL_HR,
        ST_POLL_SIGN,
        ST_POLL_VAL,
        ST_POLL_SPD,
        ST_COMMIT,
        ST_CFG_INIT,
        ST_CFG_VAL,
        ST_CFG_END
    } poll_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_ARM,
        TX_WAIT
    } txn_state_e;

endpackage

// File: rtl/wireless_poller_if.sv
// UART-side byte handshake between the poller (master) and the UART (slave).
// Latency: none, plain wires.
// Backpressure: is_transmitting holds off the next transmit pulse.
interface wireless_poller_if;
    logic       transmit;
    logic [7:0] tx_byte;
    logic       received;
    logic [7:0] rx_byte;
    logic       is_transmitting;
    logic       recv_error;

    modport master (
        output transmit, tx_byte,
        input  received, rx_byte, is_transmitting, recv_error
    );

    modport slave (
        input  transmit, tx_byte,
        output received, rx_byte, is_transmitting, recv_error
    );
endinterface

// File: rtl/wireless_txn.sv
// One request/reply exchange: send a byte, wait for a single reply byte or time out.
// Latency: transmit 1 cycle after start once the line is free; done 1 cycle after reply/timeout.
// Backpressure: holds the transmit pulse while is_transmitting is high; one request in flight.
module wireless_txn
    import wireless_pkg::*;
#(
    parameter int RESP_TIMEOUT = 500_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [7:0]         req_byte,
    output logic               done,
    output logic               ok,
    output logic [7:0]         resp_byte,
    wireless_poller_if.master  uart
);

    localparam int              TW       = $clog2(RESP_TIMEOUT) + 1;
    localparam logic [TW-1:0]   TMO_LAST = TW'(RESP_TIMEOUT - 1);

    txn_state_e     state_q, state_d;
    logic [7:0]     byte_q, byte_d;
    logic [TW-1:0]  cnt_q, cnt_d;
    logic           done_q, done_d;
    logic           ok_q, ok_d;
    logic [7:0]     resp_q, resp_d;
    logic           transmit_c;

    // Next-state: arm on start, fire once the line is idle, then wait for reply or timeout.
    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        ok_d       = 1'b0;
        resp_d     = resp_q;
        transmit_c = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (start) begin
                    byte_d  = req_byte;
                    state_d = TX_ARM;
                end
            end
            TX_ARM: begin
                if (!uart.is_transmitting) begin
                    transmit_c = 1'b1;
                    cnt_d      = '0;
                    state_d    = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (uart.received) begin
                    done_d  = 1'b1;
                    ok_d    = 1'b1;
                    resp_d  = uart.rx_byte;
                    state_d = TX_IDLE;
                end else if (uart.recv_error || (cnt_q == TMO_LAST)) begin
                    done_d  = 1'b1;
                    state_d = TX_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any request in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            byte_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            resp_q  <= resp_d;
        end
    end

    assign uart.transmit = transmit_c;
    assign uart.tx_byte  = byte_q;
    assign done          = done_q;
    assign ok            = ok_q;
    assign resp_byte     = resp_q;

endmodule

// File: rtl/wireless_poller.sv
// Polls a remote sensor for HR/angle/speed each period and issues config writes on request.
// Latency: one poll round per POLL_CYCLES; results commit one cycle after the speed reply.
// Backpressure: one UART request outstanding; wraps arriving while busy are dropped.
module wireless_poller
    import wireless_pkg::*;
#(
    parameter int POLL_CYCLES  = 5_000_000,
    parameter int RESP_TIMEOUT = 500_000,
    parameter int ERR_W        = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    wireless_poller_if.master  uart,
    input  logic               cfg_heart_req,
    input  logic [7:0]         cfg_heart_val,
    input  logic               cfg_wheel_req,
    input  logic [7:0]         cfg_wheel_val,
    output logic               cfg_done,
    output logic               cfg_err,
    output logic [7:0]         heartRate,
    output logic [9:0]         resolvedAngle,
    output logic [7:0]         speed,
    output logic               data_valid,
    output logic               link_ok,
    output logic [ERR_W-1:0]   err_count
);

    localparam int             PW        = $clog2(POLL_CYCLES) + 1;
    localparam logic [PW-1:0]  POLL_LAST = PW'(POLL_CYCLES - 1);

    poll_state_e      state_q, state_d;
    logic [PW-1:0]    timer_q, timer_d;
    logic             heart_pend_q, heart_pend_d;
    logic [7:0]       heart_val_q, heart_val_d;
    logic             wheel_pend_q, wheel_pend_d;
    logic [7:0]       wheel_val_q, wheel_val_d;
    logic             sel_wheel_q, sel_wheel_d;
    logic             cfg_fail_q, cfg_fail_d;
    logic             busy_q, busy_d;
    logic [7:0]       sh_hr_q, sh_hr_d;
    logic [1:0]       sh_sign_q, sh_sign_d;
    logic [7:0]       sh_val_q, sh_val_d;
    logic [7:0]       sh_spd_q, sh_spd_d;
    logic [7:0]       hr_q, hr_d;
    logic [9:0]       ang_q, ang_d;
    logic [7:0]       spd_q, spd_d;
    logic             dv_q, dv_d;
    logic             link_q, link_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             cdone_q, cdone_d;
    logic             cerr_q, cerr_d;

    logic             poll_wrap;
    logic             txn_state;
    logic             txn_start;
    logic [7:0]       txn_req;
    logic             txn_done;
    logic             txn_ok;
    logic [7:0]       txn_resp;
    logic             txn_good;
    logic             err_inc;

    wireless_txn #(.RESP_TIMEOUT(RESP_TIMEOUT)) u_txn (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (txn_start),
        .req_byte  (txn_req),
        .done      (txn_done),
        .ok        (txn_ok),
        .resp_byte (txn_resp),
        .uart      (uart)
    );

    assign poll_wrap = (timer_q == POLL_LAST);
    assign txn_state = (state_q == ST_POLL_HR)  || (state_q == ST_POLL_SIGN) ||
                       (state_q == ST_POLL_VAL) || (state_q == ST_POLL_SPD)  ||
                       (state_q == ST_CFG_INIT) || (state_q == ST_CFG_VAL);
    assign txn_start = txn_state && !busy_q;
    // A config step only counts if the reply arrived and it is the acknowledge byte.
    assign txn_good  = txn_ok && (txn_resp == CFG_ACK);

    // Request byte for the step the FSM is currently in.
    always_comb begin
        txn_req = '0;
        case (state_q)
            ST_POLL_HR:   txn_req = CMD_HR;
            ST_POLL_SIGN: txn_req = CMD_ANGLE_SIGN;
            ST_POLL_VAL:  txn_req = CMD_ANGLE_VALUE;
            ST_POLL_SPD:  txn_req = CMD_SPEED;
            ST_CFG_INIT:  txn_req = sel_wheel_q ? CMD_INIT_WHEEL : CMD_INIT_HEART;
            ST_CFG_VAL:   txn_req = sel_wheel_q ? wheel_val_q : heart_val_q;
            default:      txn_req = '0;
        endcase
    end

    // Sequencing FSM: config first, then poll rounds on timer wrap; any failure aborts to IDLE.
    always_comb begin
        state_d      = state_q;
        timer_d      = poll_wrap ? '0 : timer_q + 1'b1;
        heart_pend_d = heart_pend_q;
        heart_val_d  = heart_val_q;
        wheel_pend_d = wheel_pend_q;
        wheel_val_d  = wheel_val_q;
        sel_wheel_d  = sel_wheel_q;
        cfg_fail_d   = cfg_fail_q;
        busy_d       = busy_q;
        sh_hr_d      = sh_hr_q;
        sh_sign_d    = sh_sign_q;
        sh_val_d     = sh_val_q;
        sh_spd_d     = sh_spd_q;
        hr_d         = hr_q;
        ang_d        = ang_q;
        spd_d        = spd_q;
        dv_d         = 1'b0;
        link_d       = link_q;
        cdone_d      = 1'b0;
        cerr_d       = 1'b0;
        err_inc      = 1'b0;

        if (txn_start) busy_d = 1'b1;
        if (txn_done)  busy_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (heart_pend_q) begin
                    sel_wheel_d = 1'b0;
                    cfg_fail_d  = 1'b0;
                    state_d     = ST_CFG_INIT;
                end else if (wheel_pend_q) begin
                    sel_wheel_d = 1'b1;
                    cfg_fail_d  = 1'b0;
                    state_d     = ST_CFG_INIT;
                end else if (poll_wrap) begin
                    state_d = ST_POLL_HR;
                end
            end
            ST_POLL_HR, ST_POLL_SIGN, ST_POLL_VAL, ST_POLL_SPD: begin
                if (txn_done) begin
                    if (!txn_ok) begin
                        err_inc = 1'b1;
                        link_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        case (state_q)
                            ST_POLL_HR: begin
                                sh_hr_d = txn_resp;
                                state_d = ST_POLL_SIGN;
                            end
                            ST_POLL_SIGN: begin
                                sh_sign_d = txn_resp[1:0];
                                state_d   = ST_POLL_VAL;
                            end
                            ST_POLL_VAL: begin
                                sh_val_d = txn_resp;
                                state_d  = ST_POLL_SPD;
                            end
                            default: begin
                                sh_spd_d = txn_resp;
                                state_d  = ST_COMMIT;
                            end
                        endcase
                    end
                end
            end
            ST_COMMIT: begin
                hr_d    = sh_hr_q;
                ang_d   = {sh_sign_q, sh_val_q};
                spd_d   = sh_spd_q;
                dv_d    = 1'b1;
                link_d  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_CFG_INIT: begin
                if (txn_done) begin
                    if (txn_good) begin
                        state_d = ST_CFG_VAL;
                    end else begin
                        cfg_fail_d = 1'b1;
                        state_d    = ST_CFG_END;
                    end
                end
            end
            ST_CFG_VAL: begin
                if (txn_done) begin
                    if (!txn_good) cfg_fail_d = 1'b1;
                    state_d = ST_CFG_END;
                end
            end
            ST_CFG_END: begin
                cdone_d = 1'b1;
                cerr_d  = cfg_fail_q;
                err_inc = cfg_fail_q;
                link_d  = !cfg_fail_q;
                if (sel_wheel_q) wheel_pend_d = 1'b0;
                else             heart_pend_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // New requests win over the clear so a request landing on CFG_END is not lost.
        if (cfg_heart_req) begin
            heart_pend_d = 1'b1;
            heart_val_d  = cfg_heart_val;
        end
        if (cfg_wheel_req) begin
            wheel_pend_d = 1'b1;
            wheel_val_d  = cfg_wheel_val;
        end

        err_d = err_q;
        if (err_inc && (err_q != {ERR_W{1'b1}})) err_d = err_q + 1'b1;
    end

    // All poller state; reset clears outputs, timer and pending requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            heart_pend_q <= 1'b0;
            heart_val_q  <= '0;
            wheel_pend_q <= 1'b0;
            wheel_val_q  <= '0;
            sel_wheel_q  <= 1'b0;
            cfg_fail_q   <= 1'b0;
            busy_q       <= 1'b0;
            sh_hr_q      <= '0;
            sh_sign_q    <= '0;
            sh_val_q     <= '0;
            sh_spd_q     <= '0;
            hr_q         <= '0;
            ang_q        <= '0;
            spd_q        <= '0;
            dv_q         <= 1'b0;
            link_q       <= 1'b0;
            err_q        <= '0;
            cdone_q      <= 1'b0;
            cerr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            heart_pend_q <= heart_pend_d;
            heart_val_q  <= heart_val_d;
            wheel_pend_q <= wheel_pend_d;
            wheel_val_q  <= wheel_val_d;
            sel_wheel_q  <= sel_wheel_d;
            cfg_fail_q   <= cfg_fail_d;
            busy_q       <= busy_d;
            sh_hr_q      <= sh_hr_d;
            sh_sign_q    <= sh_sign_d;
            sh_val_q     <= sh_val_d;
            sh_spd_q     <= sh_spd_d;
            hr_q         <= hr_d;
            ang_q        <= ang_d;
            spd_q        <= spd_d;
            dv_q         <= dv_d;
            link_q       <= link_d;
            err_q        <= err_d;
            cdone_q      <= cdone_d;
            cerr_q       <= cerr_d;
        end
    end

    assign heartRate     = hr_q;
    assign resolvedAngle = ang_q;
    assign speed         = spd_q;
    assign data_valid    = dv_q;
    assign link_ok       = link_q;
    assign err_count     = err_q;
    assign cfg_done      = cdone_q;
    assign cfg_err       = cerr_q;

endmodule

// File: tb/tb_wireless_poller.sv
// Directed bench for wireless_poller with a scripted sensor-side responder.
// Short poll period and timeout keep every scenario to a few thousand cycles.
// Responder holds is_transmitting for 8 cycles per byte, then replies 3 cycles later.
module tb_wireless_poller;

    localparam int POLL = 2000;
    localparam int TMO  = 100;
    localparam int EW   = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_heart_req = 1'b0;
    logic [7:0]    cfg_heart_val = '0;
    logic          cfg_wheel_req = 1'b0;
    logic [7:0]    cfg_wheel_val = '0;
    logic          cfg_done;
    logic          cfg_err;
    logic [7:0]    heartRate;
    logic [9:0]    resolvedAngle;
    logic [7:0]    speed;
    logic          data_valid;
    logic          link_ok;
    logic [EW-1:0] err_count;

    always #5 clk = ~clk;

    wireless_poller_if bus ();

    wireless_poller #(.POLL_CYCLES(POLL), .RESP_TIMEOUT(TMO), .ERR_W(EW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .uart          (bus),
        .cfg_heart_req (cfg_heart_req),
        .cfg_heart_val (cfg_heart_val),
        .cfg_wheel_req (cfg_wheel_req),
        .cfg_wheel_val (cfg_wheel_val),
        .cfg_done      (cfg_done),
        .cfg_err       (cfg_err),
        .heartRate     (heartRate),
        .resolvedAngle (resolvedAngle),
        .speed         (speed),
        .data_valid    (data_valid),
        .link_ok       (link_ok),
        .err_count     (err_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Responder script
    logic [7:0] hr_rep    = 8'd72;
    logic [7:0] sign_rep  = 8'hA6;   // low bits 2'b10, upper bits must be dropped
    logic [7:0] val_rep   = 8'h3C;
    logic [7:0] spd_rep   = 8'd25;
    logic [7:0] ack_heart = 8'd1;
    logic [7:0] ack_wheel = 8'd1;
    logic [7:0] ack_val   = 8'd1;
    logic [7:0] silent_cmd = 8'd0;
    bit         expect_val = 1'b0;
    logic [7:0] tx_log[$];
    int         busy_viol = 0;

    initial begin
        logic [7:0] b;
        logic [7:0] rep;
        bit         do_rep;
        bus.received        = 1'b0;
        bus.rx_byte         = '0;
        bus.is_transmitting = 1'b0;
        bus.recv_error      = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus.transmit === 1'b1) begin
                b = bus.tx_byte;
                tx_log.push_back(b);
                if (bus.is_transmitting) busy_viol++;
                do_rep = 1'b1;
                rep    = 8'd0;
                if (!expect_val && (silent_cmd != 8'd0) && (b == silent_cmd)) do_rep = 1'b0;
                if (expect_val) begin
                    rep        = ack_val;
                    expect_val = 1'b0;
                end else begin
                    case (b)
                        8'd1: rep = hr_rep;
                        8'd2: rep = sign_rep;
                        8'd3: rep = val_rep;
                        8'd4: rep = spd_rep;
                        8'd5: begin rep = ack_heart; expect_val = (ack_heart == 8'd1); end
                        8'd6: begin rep = ack_wheel; expect_val = (ack_wheel == 8'd1); end
                        default: rep = 8'd0;
                    endcase
                end
                @(posedge clk); #1;
                bus.is_transmitting = 1'b1;
                repeat (8) @(posedge clk);
                #1 bus.is_transmitting = 1'b0;
                repeat (3) @(posedge clk);
                if (do_rep) begin
                    #1;
                    bus.received = 1'b1;
                    bus.rx_byte  = rep;
                    @(posedge clk); #1;
                    bus.received = 1'b0;
                end
            end
        end
    end

    // Pulse counters sampled on the falling edge
    int         dv_cnt = 0;
    int         cd_cnt = 0;
    logic       last_cfg_err = 1'b0;
    int         tx_in_rst = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (data_valid === 1'b1) dv_cnt++;
            if (cfg_done === 1'b1) begin
                cd_cnt++;
                last_cfg_err = cfg_err;
            end
            if (!rst_n && (bus.transmit !== 1'b0)) tx_in_rst++;
        end
    end

    task automatic wait_dv(input int target, input string tag);
        int n = 0;
        while (dv_cnt < target && n < 3 * POLL) begin
            @(negedge clk);
            n++;
        end
        chk_val(tag, dv_cnt, target);
    endtask

    task automatic wait_cd(input int target, input string tag);
        int n = 0;
        while (cd_cnt < target && n < POLL) begin
            @(negedge clk);
            n++;
        end
        chk_val(tag, cd_cnt, target);
    endtask

    task automatic chk_log(input string tag, input logic [7:0] exp[$]);
        chk_val({tag, " len"}, tx_log.size(), exp.size());
        for (int i = 0; i < exp.size() && i < tx_log.size(); i++)
            chk_val($sformatf("%s byte%0d", tag, i), tx_log[i], exp[i]);
    endtask

    initial begin
        int n;
        logic [7:0] first_tx;
        repeat (3) @(negedge clk);

        // Reset state
        chk_val("rst heartRate", heartRate, 0);
        chk_val("rst angle", resolvedAngle, 0);
        chk_val("rst speed", speed, 0);
        chk_val("rst link_ok", link_ok, 0);
        chk_val("rst err_count", err_count, 0);
        chk_val("rst pulses", {data_valid, cfg_done, cfg_err}, 0);
        chk_val("rst transmit", bus.transmit, 0);
        chk_val("rst tx_byte", bus.tx_byte, 0);
        rst_n = 1'b1;

        // Round 1: full successful poll
        wait_dv(1, "round1 dv");
        chk_val("r1 heartRate", heartRate, 72);
        chk_val("r1 angle", resolvedAngle, 10'h23C);
        chk_val("r1 speed", speed, 25);
        chk_val("r1 link_ok", link_ok, 1);
        chk_val("r1 err_count", err_count, 0);
        chk_log("r1 tx", '{8'd1, 8'd2, 8'd3, 8'd4});
        repeat (5) @(negedge clk);
        chk_val("r1 single dv", dv_cnt, 1);

        // Round 2: silent on ANGLE_VALUE -> abort
        silent_cmd = 8'd3;
        hr_rep     = 8'd80;
        n = 0;
        while (err_count == 0 && n < 3 * POLL) begin
            @(negedge clk);
            n++;
        end
        chk_val("r2 err_count", err_count, 1);
        chk_val("r2 link_ok", link_ok, 0);
        chk_val("r2 heartRate kept", heartRate, 72);
        chk_val("r2 angle kept", resolvedAngle, 10'h23C);
        chk_val("r2 speed kept", speed, 25);
        chk_val("r2 no dv", dv_cnt, 1);

        // Round 3 recovers
        silent_cmd = 8'd0;
        wait_dv(2, "round3 dv");
        chk_val("r3 heartRate", heartRate, 80);
        chk_val("r3 link_ok", link_ok, 1);

        // Heart config 180 right after a commit (FSM idle)
        tx_log.delete();
        cfg_heart_val = 8'd180;
        cfg_heart_req = 1'b1;
        @(negedge clk);
        cfg_heart_req = 1'b0;
        wait_cd(1, "cfg heart done");
        chk_val("cfg heart err", last_cfg_err, 0);
        chk_log("cfg heart tx", '{8'd5, 8'd180});

        // Simultaneous heart 190 and wheel 26
        tx_log.delete();
        cfg_heart_val = 8'd190;
        cfg_wheel_val = 8'd26;
        cfg_heart_req = 1'b1;
        cfg_wheel_req = 1'b1;
        @(negedge clk);
        cfg_heart_req = 1'b0;
        cfg_wheel_req = 1'b0;
        wait_cd(3, "cfg both done");
        chk_val("cfg both err", last_cfg_err, 0);
        chk_log("cfg both tx", '{8'd5, 8'd190, 8'd6, 8'd26});
        chk_val("cfg both no poll", dv_cnt, 2);

        // Wheel init refused
        tx_log.delete();
        ack_wheel     = 8'd0;
        cfg_wheel_val = 8'd27;
        cfg_wheel_req = 1'b1;
        @(negedge clk);
        cfg_wheel_req = 1'b0;
        wait_cd(4, "cfg nack done");
        chk_val("cfg nack err", last_cfg_err, 1);
        chk_log("cfg nack tx", '{8'd6});
        chk_val("cfg nack err_count", err_count, 2);
        chk_val("cfg nack link_ok", link_ok, 0);
        ack_wheel = 8'd1;
        chk_val("busy gating", busy_viol, 0);

        // Reset while waiting for the SPD reply
        tx_log.delete();
        n = 0;
        while (!(tx_log.size() > 0 && tx_log[tx_log.size() - 1] == 8'd4) && n < 3 * POLL) begin
            @(negedge clk);
            n++;
        end
        chk_val("spd tx seen", (tx_log.size() > 0) ? tx_log[tx_log.size() - 1] : 8'd0, 4);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_val("arst heartRate", heartRate, 0);
        chk_val("arst angle", resolvedAngle, 0);
        chk_val("arst speed", speed, 0);
        chk_val("arst link/err", {link_ok, err_count}, 0);
        repeat (20) @(negedge clk);
        chk_val("no tx in reset", tx_in_rst, 0);
        rst_n = 1'b1;
        n = 0;
        first_tx = 8'hFF;
        while (n < 3 * POLL) begin
            @(negedge clk);
            n++;
            if (bus.transmit === 1'b1) begin
                first_tx = bus.tx_byte;
                break;
            end
        end
        chk_val("post-rst first tx byte", first_tx, 1);
        chk_val("post-rst first tx at wrap", (n >= POLL - 2) && (n <= POLL + 4), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
